// File: rtl/recorder_ctrl.sv
// Record/playback controller: interleaved multi-channel samples go to SRAM on record and stream back to the DAC on play.
// Reverse playback is built only when RECORDER_REVERSE_EN is defined.
module recorder_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 18,
    parameter int CHANNELS = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              cmd_pause,
    input  logic [1:0]        speed,
    input  logic              reverse,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [CH_W-1:0]   adc_ch,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic [CH_W-1:0]   dac_ch,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        state_o,
    output logic              full,
    output logic              done
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0]   LAST_ADDR   = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [PW-1:0]   FRAME_WORDS = PW'(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH     = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_len;
    logic [CH_W-1:0]   r_wr_ch, r_play_ch, r_sil_ch;
    logic              r_armed, r_full, r_done;
    logic              r_s1_valid, r_s1_silent, r_s2_valid, r_s2_silent;
    logic [CH_W-1:0]   r_s1_ch, r_s2_ch, r_dac_ch;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata, r_dac_data;
    logic              r_sram_we, r_sram_re, r_dac_valid;

    logic              w_start_rec, w_start_play, w_finalize, w_full_set;
    logic              w_wr_go, w_rd_go, w_play_end, w_sil, w_accept, w_frame_end, w_last_frame;
    logic [PW-1:0]     w_wr_ptr_inc, w_step, w_fwd_nxt, w_rd_ptr_adv, w_rd_ptr_start, w_len_fin;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [CH_W-1:0]   w_wr_ch_inc, w_play_ch_inc, w_sil_ch_inc;

    assign w_wr_ptr_inc  = r_wr_ptr + PW'(1'b1);
    assign w_wr_ch_inc   = (r_wr_ch == LAST_CH) ? {CH_W{1'b0}} : r_wr_ch + CH_W'(1'b1);
    assign w_play_ch_inc = r_play_ch + CH_W'(1'b1);
    assign w_sil_ch_inc  = (r_sil_ch == LAST_CH) ? {CH_W{1'b0}} : r_sil_ch + CH_W'(1'b1);
    assign w_step        = PW'((32'(speed) + 32'd1) * 32'(CHANNELS));
    assign w_fwd_nxt     = r_rd_ptr + w_step;
    assign w_rd_addr     = ADDR_W'(r_rd_ptr + PW'(r_play_ch));
    assign w_frame_end   = (r_play_ch == LAST_CH);
    assign w_accept      = adc_valid && (!r_armed || (adc_ch == {CH_W{1'b0}}));
    assign w_sil         = dac_req && !w_rd_go;
    // A full stop counts the word being written now; trailing partial frame is dropped either way.
    assign w_len_fin     = w_full_set ? (w_wr_ptr_inc - PW'(w_wr_ch_inc)) : (r_wr_ptr - PW'(r_wr_ch));

`ifdef RECORDER_REVERSE_EN
    logic r_rev;
    assign w_last_frame   = r_rev ? (r_rd_ptr < w_step) : (w_fwd_nxt >= r_len);
    assign w_rd_ptr_adv   = r_rev ? (r_rd_ptr - w_step) : w_fwd_nxt;
    assign w_rd_ptr_start = reverse ? (r_len - FRAME_WORDS) : {PW{1'b0}};

    // Play direction latched at play start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rev <= 1'b0;
        end else if (w_start_play) begin
            r_rev <= reverse;
        end
    end
`else
    logic w_unused_reverse;
    assign w_unused_reverse = reverse;
    assign w_last_frame     = (w_fwd_nxt >= r_len);
    assign w_rd_ptr_adv     = w_fwd_nxt;
    assign w_rd_ptr_start   = {PW{1'b0}} & FRAME_WORDS;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control strobes; command priority stop > record > play > pause
    always_comb begin
        w_state_nxt  = r_state;
        w_start_rec  = 1'b0;
        w_start_play = 1'b0;
        w_finalize   = 1'b0;
        w_full_set   = 1'b0;
        w_wr_go      = 1'b0;
        w_rd_go      = 1'b0;
        w_play_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (cmd_record) begin
                    w_state_nxt = S_RECORD;
                    w_start_rec = 1'b1;
                end else if (cmd_play && (r_len != {PW{1'b0}})) begin
                    w_state_nxt  = S_PLAY;
                    w_start_play = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECORD: begin
                if (cmd_stop) begin
                    w_state_nxt = S_IDLE;
                    w_finalize  = 1'b1;
                end else if (cmd_record) begin
                    w_start_rec = 1'b1;
                end else if (w_accept) begin
                    w_wr_go = 1'b1;
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_full_set  = 1'b1;
                        w_finalize  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RECORD;
                    end
                end else begin
                    w_state_nxt = S_RECORD;
                end
            end
            S_PLAY: begin
                if (cmd_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (cmd_record) begin
                    w_state_nxt = S_RECORD;
                    w_start_rec = 1'b1;
                end else if (cmd_pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (dac_req) begin
                    w_rd_go = 1'b1;
                    if (w_frame_end && w_last_frame) begin
                        w_play_end  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PLAY;
                    end
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (cmd_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (cmd_record) begin
                    w_state_nxt = S_RECORD;
                    w_start_rec = 1'b1;
                end else if (cmd_pause) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_state_nxt = S_PAUSE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointers, lengths, SRAM strobes and the three-stage DAC return pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= {PW{1'b0}};
            r_rd_ptr     <= {PW{1'b0}};
            r_len        <= {PW{1'b0}};
            r_wr_ch      <= {CH_W{1'b0}};
            r_play_ch    <= {CH_W{1'b0}};
            r_sil_ch     <= {CH_W{1'b0}};
            r_armed      <= 1'b0;
            r_full       <= 1'b0;
            r_done       <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_silent  <= 1'b0;
            r_s1_ch      <= {CH_W{1'b0}};
            r_s2_valid   <= 1'b0;
            r_s2_silent  <= 1'b0;
            r_s2_ch      <= {CH_W{1'b0}};
            r_sram_addr  <= {ADDR_W{1'b0}};
            r_sram_wdata <= {DATA_W{1'b0}};
            r_sram_we    <= 1'b0;
            r_sram_re    <= 1'b0;
            r_dac_data   <= {DATA_W{1'b0}};
            r_dac_ch     <= {CH_W{1'b0}};
            r_dac_valid  <= 1'b0;
        end else begin
            r_sram_we <= 1'b0;
            r_sram_re <= 1'b0;
            r_done    <= w_play_end;
            if (w_start_rec) begin
                r_wr_ptr <= {PW{1'b0}};
                r_wr_ch  <= {CH_W{1'b0}};
                r_len    <= {PW{1'b0}};
                r_full   <= 1'b0;
                r_armed  <= 1'b1;
            end else if (w_wr_go) begin
                r_sram_we    <= 1'b1;
                r_sram_addr  <= r_wr_ptr[ADDR_W-1:0];
                r_sram_wdata <= adc_data;
                r_wr_ptr     <= w_wr_ptr_inc;
                r_wr_ch      <= w_wr_ch_inc;
                r_armed      <= 1'b0;
            end
            if (w_full_set) begin
                r_full <= 1'b1;
            end
            if (w_finalize) begin
                r_len <= w_len_fin;
            end
            if (w_start_play) begin
                r_play_ch <= {CH_W{1'b0}};
                r_rd_ptr  <= w_rd_ptr_start;
            end else if (w_rd_go) begin
                r_sram_re   <= 1'b1;
                r_sram_addr <= w_rd_addr;
                if (w_frame_end) begin
                    r_play_ch <= {CH_W{1'b0}};
                    r_rd_ptr  <= w_rd_ptr_adv;
                end else begin
                    r_play_ch <= w_play_ch_inc;
                end
            end
            if (w_sil) begin
                r_sil_ch <= w_sil_ch_inc;
            end
            r_s1_valid  <= dac_req;
            r_s1_silent <= w_sil;
            r_s1_ch     <= w_rd_go ? r_play_ch : r_sil_ch;
            r_s2_valid  <= r_s1_valid;
            r_s2_silent <= r_s1_silent;
            r_s2_ch     <= r_s1_ch;
            r_dac_valid <= r_s2_valid;
            r_dac_ch    <= r_s2_valid ? r_s2_ch : {CH_W{1'b0}};
            r_dac_data  <= (r_s2_valid && !r_s2_silent) ? sram_rdata : {DATA_W{1'b0}};
        end
    end

    assign state_o    = r_state;
    assign full       = r_full;
    assign done       = r_done;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign sram_we    = r_sram_we;
    assign sram_re    = r_sram_re;
    assign dac_data   = r_dac_data;
    assign dac_ch     = r_dac_ch;
    assign dac_valid  = r_dac_valid;
endmodule

// File: tb/tb_recorder_ctrl.sv
// Directed bench for recorder_ctrl (2 channels, 16-word SRAM); expects reverse order only with RECORDER_REVERSE_EN.
module tb_recorder_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 1;
    localparam logic [3:0] M_STOP  = 4'b1000;
    localparam logic [3:0] M_REC   = 4'b0100;
    localparam logic [3:0] M_PLAY  = 4'b0010;
    localparam logic [3:0] M_PAUSE = 4'b0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_record = 1'b0, cmd_play = 1'b0, cmd_stop = 1'b0, cmd_pause = 1'b0;
    logic [1:0]    speed = 2'd0;
    logic          reverse = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [CW-1:0] adc_ch = '0;
    logic          dac_req = 1'b0;
    logic [DW-1:0] dac_data, sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [CW-1:0] dac_ch;
    logic          dac_valid, sram_we, sram_re, full, done;
    logic [AW-1:0] sram_addr;
    logic [1:0]    state_o;

    logic [DW-1:0] mem [16];
    int wq_addr[$], wq_data[$], rq_addr[$], dq_data[$], dq_ch[$];
    int coll = 0;
    int errors = 0;
    int checks = 0;
    int e[8];
    int rev_exp[8];

    recorder_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_stop(cmd_stop), .cmd_pause(cmd_pause),
        .speed(speed), .reverse(reverse),
        .adc_valid(adc_valid), .adc_data(adc_data), .adc_ch(adc_ch),
        .dac_req(dac_req), .dac_data(dac_data), .dac_ch(dac_ch), .dac_valid(dac_valid),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_re(sram_re),
        .sram_rdata(sram_rdata), .state_o(state_o), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: read data valid the cycle after sram_re
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    // Transaction log sampled mid-cycle
    always @(negedge clk) begin
        if (sram_we) begin wq_addr.push_back(int'(sram_addr)); wq_data.push_back(int'(sram_wdata)); end
        if (sram_re) rq_addr.push_back(int'(sram_addr));
        if (dac_valid) begin dq_data.push_back(int'(dac_data)); dq_ch.push_back(int'(dac_ch)); end
        if (sram_we && sram_re) coll++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        {cmd_stop, cmd_record, cmd_play, cmd_pause} = m;
        @(negedge clk);
        {cmd_stop, cmd_record, cmd_play, cmd_pause} = 4'b0000;
    endtask

    task automatic adc(input int d, input int ch);
        adc_valid = 1'b1; adc_data = DW'(d); adc_ch = CW'(ch);
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic dac;
        dac_req = 1'b1;
        @(negedge clk);
        dac_req = 1'b0;
    endtask

    task automatic clear_q;
        wq_addr.delete(); wq_data.delete(); rq_addr.delete(); dq_data.delete(); dq_ch.delete();
    endtask

    task automatic check_reads(input string tag, input int n, input int ea[8], input int base);
        check_eq({tag, "_nrd"}, rq_addr.size(), n);
        check_eq({tag, "_ndac"}, dq_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rq_addr.size()) check_eq($sformatf("%s_addr%0d", tag, i), rq_addr[i], ea[i]);
            if (i < dq_data.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), dq_data[i], base + ea[i]);
                check_eq($sformatf("%s_ch%0d", tag, i), dq_ch[i], i % 2);
            end
        end
    endtask

    initial begin
`ifdef RECORDER_REVERSE_EN
        rev_exp = '{6, 7, 4, 5, 2, 3, 0, 1};
`else
        rev_exp = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {30'd0, state_o}, 32'd0);
        check_eq("rst_flags", {27'd0, full, done, dac_valid, sram_we, sram_re}, 32'd0);
        check_eq("rst_data", {12'd0, sram_addr, dac_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        pulse(M_PLAY);
        check_eq("play_empty", state_o, 2'd0);
        pulse(M_STOP | M_REC);
        check_eq("prio_stop", state_o, 2'd0);

        // Record 10 samples starting on channel 1: first one is dropped while armed
        pulse(M_REC);
        check_eq("rec_state", state_o, 2'd1);
        clear_q();
        for (int i = 0; i < 10; i++) begin
            adc(32'h101 + i - 1, (i % 2 == 0) ? 1 : 0);
            if (i == 0) check_eq("armed_drop", sram_we, 1'b0);
            if (i == 1) check_eq("wr_lat", {sram_we, 11'd0, sram_addr, sram_wdata}, {1'b1, 11'd0, 4'd0, 16'h0101});
        end
        pulse(M_STOP);
        check_eq("stop_state", state_o, 2'd0);
        check_eq("nwrites", wq_addr.size(), 9);
        check_eq("w_first", {wq_addr[0], wq_data[0]}, {32'd0, 32'h101});
        check_eq("w_last", {wq_addr[8], wq_data[8]}, {32'd8, 32'h109});

        // Forward play, speed 0: reads 0..7; address 8 is beyond len_words=8
        speed = 2'd0; reverse = 1'b0;
        pulse(M_PLAY);
        check_eq("play_state", state_o, 2'd2);
        clear_q();
        dac_req = 1'b1;
        @(negedge clk);
        dac_req = 1'b0;
        check_eq("rd_lat_re", {sram_re, 27'd0, sram_addr}, {1'b1, 27'd0, 4'd0});
        @(negedge clk);
        check_eq("rd_lat_n2", dac_valid, 1'b0);
        @(negedge clk);
        check_eq("rd_lat_n3", {dac_valid, 15'd0, dac_data}, {1'b1, 15'd0, 16'h0101});
        for (int i = 1; i < 8; i++) begin
            if (i == 7) check_eq("not_done_yet", state_o, 2'd2);
            dac();
        end
        check_eq("fwd_done", {done, state_o}, {1'b1, 2'd0});
        @(negedge clk);
        check_eq("done_pulse", done, 1'b0);
        repeat (3) @(negedge clk);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_reads("fwd", 8, e, 32'h101);

        // Speed 1: one frame skipped between frames
        speed = 2'd1;
        pulse(M_PLAY);
        clear_q();
        for (int i = 0; i < 4; i++) dac();
        check_eq("spd1_done", {done, state_o}, {1'b1, 2'd0});
        repeat (4) @(negedge clk);
        e = '{0, 1, 4, 5, 0, 0, 0, 0};
        check_reads("spd1", 4, e, 32'h101);

        // Reverse request
        speed = 2'd0; reverse = 1'b1;
        pulse(M_PLAY);
        reverse = 1'b0;
        clear_q();
        for (int i = 0; i < 8; i++) dac();
        check_eq("rev_done", {done, state_o}, {1'b1, 2'd0});
        repeat (4) @(negedge clk);
        check_reads("rev", 8, rev_exp, 32'h101);

        // Fill all 16 words: full with the last write, then ignore further samples
        pulse(M_REC);
        clear_q();
        for (int i = 0; i < 16; i++) adc(32'h200 + i, i % 2);
        check_eq("full_last", {full, sram_we, 26'd0, state_o, sram_addr}, {1'b1, 1'b1, 26'd0, 2'd0, 4'd15});
        adc(32'h2AA, 0);
        adc(32'h2BB, 1);
        repeat (2) @(negedge clk);
        check_eq("full_nwr", wq_addr.size(), 16);
        speed = 2'd3;
        pulse(M_PLAY);
        clear_q();
        for (int i = 0; i < 4; i++) dac();
        check_eq("spd3_done", {done, state_o}, {1'b1, 2'd0});
        repeat (4) @(negedge clk);
        e = '{0, 1, 8, 9, 0, 0, 0, 0};
        check_reads("spd3", 4, e, 32'h200);
        check_eq("full_sticky", full, 1'b1);

        // Pause / resume
        pulse(M_REC);
        check_eq("full_clr", full, 1'b0);
        for (int i = 0; i < 8; i++) adc(32'h300 + i, i % 2);
        pulse(M_STOP);
        speed = 2'd0;
        pulse(M_PLAY);
        clear_q();
        for (int i = 0; i < 3; i++) dac();
        pulse(M_PAUSE);
        check_eq("pause_state", state_o, 2'd3);
        dac();
        dac();
        repeat (4) @(negedge clk);
        check_eq("pause_nrd", rq_addr.size(), 3);
        check_eq("pause_ndac", dq_data.size(), 5);
        if (dq_data.size() == 5) check_eq("silence", {dq_data[3], dq_data[4]}, 64'd0);
        pulse(M_PAUSE);
        check_eq("resume_state", state_o, 2'd2);
        clear_q();
        dac();
        repeat (4) @(negedge clk);
        check_eq("resume_nrd", rq_addr.size(), 1);
        if (rq_addr.size() == 1) check_eq("resume_addr", {rq_addr[0], dq_data[0]}, {32'd3, 32'h303});

        // Asynchronous reset mid-play
        check_eq("pre_rst_state", state_o, 2'd2);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_flags", {27'd0, full, done, dac_valid, sram_we, sram_re}, 32'd0);
        check_eq("arst_state", {10'd0, state_o, sram_addr, dac_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse(M_PLAY);
        check_eq("play_after_rst", state_o, 2'd0);
        check_eq("we_re_excl", coll, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
